// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_capture_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Capture FSM: waiting for first rise, inside high phase, inside low phase.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM input and measurement results bundled as one port.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = pwm_capture_pkg::CNT_W_DEF
);
    logic             pwm;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    // Capture block side: consumes the waveform, produces the measurements.
    modport slave (
        input  pwm,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck,
        output stuck_level
    );

    // Source/observer side: drives the waveform, reads the measurements.
    modport master (
        output pwm,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck,
        input  stuck_level
    );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus rise/fall strobes.
module pwm_capture_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o  = sync_q;
    assign rise_c_o = sync_q & ~prev_q;
    assign fall_c_o = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input; flags a line with no edges.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave cap_if
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic pwm_s;
    logic rise_c;
    logic fall_c;
    logic edge_c;
    logic expire_c;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
    logic [CNT_W-1:0] per_cnt_q,    per_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic [CNT_W-1:0] high_out_q,   high_out_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_q,      stuck_d;
    logic             stuck_lvl_q,  stuck_lvl_d;

    pwm_capture_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_i  (cap_if.pwm),
        .level_o  (pwm_s),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    assign edge_c   = rise_c | fall_c;
    // An edge in the expiry cycle cancels the timeout.
    assign expire_c = ~edge_c & (idle_cnt_q == IDLE_LAST);

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hi_cnt_q     <= '0;
            per_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            high_out_q   <= '0;
            period_out_q <= '0;
            meas_valid_q <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_lvl_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
            per_cnt_q    <= per_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            high_out_q   <= high_out_d;
            period_out_q <= period_out_d;
            meas_valid_q <= meas_valid_d;
            stuck_q      <= stuck_d;
            stuck_lvl_q  <= stuck_lvl_d;
        end
    end

    // Next-state: edge-driven measurement FSM plus idle timeout supervision.
    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        per_cnt_d    = per_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        high_out_d   = high_out_q;
        period_out_d = period_out_q;
        meas_valid_d = 1'b0;
        stuck_d      = stuck_q;
        stuck_lvl_d  = stuck_lvl_q;

        // Idle counter saturates at its expiry value while the line stays quiet.
        if (edge_c) begin
            idle_cnt_d = '0;
            stuck_d    = 1'b0;
        end else if (expire_c) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = pwm_s;
        end else begin
            idle_cnt_d = idle_cnt_q + CNT_ONE;
        end

        if (expire_c) begin
            state_d   = S_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise_c) begin
                        state_d   = S_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    per_cnt_d = per_cnt_q + CNT_ONE;
                    if (fall_c) begin
                        state_d = S_LOW;
                    end else begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (rise_c) begin
                        high_out_d   = hi_cnt_q;
                        period_out_d = per_cnt_q;
                        meas_valid_d = 1'b1;
                        state_d      = S_HIGH;
                        hi_cnt_d     = CNT_ONE;
                        per_cnt_d    = CNT_ONE;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
            endcase
        end
    end

    assign cap_if.high_cnt    = high_out_q;
    assign cap_if.period_cnt  = period_out_q;
    assign cap_if.meas_valid  = meas_valid_q;
    assign cap_if.stuck       = stuck_q;
    assign cap_if.stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with CNT_W=16, TIMEOUT=64.
module tb_pwm_capture;

    localparam int unsigned CW = 16;

    logic clk;
    logic rst_n;

    pwm_capture_if #(.CNT_W(CW)) bus ();

    pwm_capture #(.CNT_W(CW), .TIMEOUT(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_if (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Pulse observer: counts MEAS_VALID pulses and remembers the last values.
    int unsigned cyc_cnt     = 0;
    int unsigned mv_cnt      = 0;
    int unsigned b2b_cnt     = 0;
    int unsigned mv_gap      = 0;
    int unsigned last_mv_cyc = 0;
    logic        prev_mv     = 1'b0;
    logic [CW-1:0] last_hi   = '0;
    logic [CW-1:0] last_per  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (bus.meas_valid === 1'b1) begin
            mv_cnt   = mv_cnt + 1;
            last_hi  = bus.high_cnt;
            last_per = bus.period_cnt;
            if (prev_mv === 1'b1) b2b_cnt = b2b_cnt + 1;
            mv_gap      = cyc_cnt - last_mv_cyc;
            last_mv_cyc = cyc_cnt;
        end
        prev_mv = bus.meas_valid;
    end

    // One sampled PWM cycle; returns just after the following falling edge.
    task automatic cyc(input logic v);
        bus.pwm = v;
        @(negedge clk);
        #1;
    endtask

    task automatic period(input int h, input int p);
        for (int i = 0; i < p; i++) cyc(i < h);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.high_cnt !== 16'd0) begin n_err++; $display("FAIL reset_high: got %0d want 0", bus.high_cnt); end
        n_cmp++; if (bus.period_cnt !== 16'd0) begin n_err++; $display("FAIL reset_period: got %0d want 0", bus.period_cnt); end
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.meas_valid); end
        n_cmp++; if (bus.stuck !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %0b want 0", bus.stuck); end
        n_cmp++; if (bus.stuck_level !== 1'b0) begin n_err++; $display("FAIL reset_level: got %0b want 0", bus.stuck_level); end
    endtask

    task automatic test_basic();
        int unsigned mv0;
        mv0 = mv_cnt;
        for (int i = 0; i < 4; i++) period(5, 16);
        n_cmp++; if (mv_cnt - mv0 !== 3) begin n_err++; $display("FAIL basic_pulses: got %0d want 3", mv_cnt - mv0); end
        n_cmp++; if (last_hi !== 16'd5) begin n_err++; $display("FAIL basic_high: got %0d want 5", last_hi); end
        n_cmp++; if (last_per !== 16'd16) begin n_err++; $display("FAIL basic_period: got %0d want 16", last_per); end
        n_cmp++; if (mv_gap !== 16) begin n_err++; $display("FAIL basic_gap: got %0d want 16", mv_gap); end
    endtask

    task automatic test_latency();
        cyc(1'b1);
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_k0: got %0b want 0", bus.meas_valid); end
        cyc(1'b1);
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_k1: got %0b want 0", bus.meas_valid); end
        cyc(1'b1);
        n_cmp++; if (bus.meas_valid !== 1'b1) begin n_err++; $display("FAIL lat_k2: got %0b want 1", bus.meas_valid); end
        n_cmp++; if (bus.high_cnt !== 16'd5 || bus.period_cnt !== 16'd16)
            begin n_err++; $display("FAIL lat_counts: got %0d/%0d want 5/16", bus.high_cnt, bus.period_cnt); end
        cyc(1'b1);
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_pulse_width: got %0b want 0", bus.meas_valid); end
        cyc(1'b1);
        for (int i = 0; i < 11; i++) cyc(1'b0);
    endtask

    task automatic test_sweep();
        for (int h = 1; h <= 15; h++) begin
            period(h, 16);
            period(h, 16);
            n_cmp++; if (last_hi !== 16'(h) || last_per !== 16'd16)
                begin n_err++; $display("FAIL sweep_h%0d: got %0d/%0d want %0d/16", h, last_hi, last_per, h); end
        end
    endtask

    task automatic test_glitch();
        period(1, 8);
        period(1, 8);
        n_cmp++; if (last_hi !== 16'd1 || last_per !== 16'd8)
            begin n_err++; $display("FAIL glitch: got %0d/%0d want 1/8", last_hi, last_per); end
    endtask

    task automatic test_min_period();
        int unsigned mv0;
        mv0 = mv_cnt;
        for (int i = 0; i < 4; i++) period(1, 2);
        cyc(1'b0);
        cyc(1'b0);
        n_cmp++; if (mv_cnt - mv0 !== 4) begin n_err++; $display("FAIL min_pulses: got %0d want 4", mv_cnt - mv0); end
        n_cmp++; if (last_hi !== 16'd1 || last_per !== 16'd2)
            begin n_err++; $display("FAIL min_counts: got %0d/%0d want 1/2", last_hi, last_per); end
        n_cmp++; if (mv_gap !== 2) begin n_err++; $display("FAIL min_gap: got %0d want 2", mv_gap); end
    endtask

    task automatic test_stuck();
        int unsigned mv0;
        mv0 = mv_cnt;
        for (int i = 0; i < 66; i++) cyc(1'b1);
        n_cmp++; if (bus.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_hi_early: got %0b want 0", bus.stuck); end
        cyc(1'b1);
        n_cmp++; if (bus.stuck !== 1'b1) begin n_err++; $display("FAIL stuck_hi_set: got %0b want 1", bus.stuck); end
        n_cmp++; if (bus.stuck_level !== 1'b1) begin n_err++; $display("FAIL stuck_hi_level: got %0b want 1", bus.stuck_level); end
        for (int i = 0; i < 10; i++) cyc(1'b1);
        n_cmp++; if (bus.high_cnt !== 16'd1 || bus.period_cnt !== 16'd4)
            begin n_err++; $display("FAIL stuck_hi_hold: got %0d/%0d want 1/4", bus.high_cnt, bus.period_cnt); end
        n_cmp++; if (mv_cnt - mv0 !== 1) begin n_err++; $display("FAIL stuck_hi_pulses: got %0d want 1", mv_cnt - mv0); end
        cyc(1'b0);
        cyc(1'b0);
        n_cmp++; if (bus.stuck !== 1'b1) begin n_err++; $display("FAIL stuck_clr_early: got %0b want 1", bus.stuck); end
        cyc(1'b0);
        n_cmp++; if (bus.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_clr_fall: got %0b want 0", bus.stuck); end
        for (int i = 0; i < 70; i++) cyc(1'b0);
        n_cmp++; if (bus.stuck !== 1'b1 || bus.stuck_level !== 1'b0)
            begin n_err++; $display("FAIL stuck_lo: got stuck=%0b level=%0b want 1/0", bus.stuck, bus.stuck_level); end
        n_cmp++; if (bus.high_cnt !== 16'd1 || bus.period_cnt !== 16'd4)
            begin n_err++; $display("FAIL stuck_lo_hold: got %0d/%0d want 1/4", bus.high_cnt, bus.period_cnt); end
        mv0 = mv_cnt;
        period(5, 16);
        n_cmp++; if (bus.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_clr_rise: got %0b want 0", bus.stuck); end
        n_cmp++; if (mv_cnt - mv0 !== 0) begin n_err++; $display("FAIL resume_early: got %0d pulses want 0", mv_cnt - mv0); end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        n_cmp++; if (mv_cnt - mv0 !== 1 || last_hi !== 16'd5 || last_per !== 16'd16)
            begin n_err++; $display("FAIL resume: got %0d pulses %0d/%0d want 1 5/16", mv_cnt - mv0, last_hi, last_per); end
        cyc(1'b1);
        cyc(1'b1);
        for (int i = 0; i < 11; i++) cyc(1'b0);
    endtask

    task automatic test_edge_vs_timeout();
        for (int i = 0; i < 64; i++) cyc(1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0);
        n_cmp++; if (bus.stuck !== 1'b0) begin n_err++; $display("FAIL edge_wins: got %0b want 0", bus.stuck); end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        n_cmp++; if (last_hi !== 16'd64 || last_per !== 16'd80)
            begin n_err++; $display("FAIL edge_counts: got %0d/%0d want 64/80", last_hi, last_per); end
    endtask

    task automatic test_reset_mid();
        int unsigned mv0;
        cyc(1'b1);
        cyc(1'b1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.high_cnt !== 16'd0 || bus.period_cnt !== 16'd0)
            begin n_err++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", bus.high_cnt, bus.period_cnt); end
        n_cmp++; if (bus.meas_valid !== 1'b0 || bus.stuck !== 1'b0 || bus.stuck_level !== 1'b0)
            begin n_err++; $display("FAIL rstmid_flags: got v=%0b s=%0b l=%0b want 0", bus.meas_valid, bus.stuck, bus.stuck_level); end
        for (int i = 0; i < 3; i++) cyc(1'b0);
        rst_n = 1'b1;
        mv0 = mv_cnt;
        cyc(1'b0);
        period(5, 16);
        n_cmp++; if (mv_cnt - mv0 !== 0 || bus.high_cnt !== 16'd0)
            begin n_err++; $display("FAIL rstmid_first: got %0d pulses high=%0d want 0/0", mv_cnt - mv0, bus.high_cnt); end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        n_cmp++; if (mv_cnt - mv0 !== 1 || last_hi !== 16'd5 || last_per !== 16'd16)
            begin n_err++; $display("FAIL rstmid_second: got %0d pulses %0d/%0d want 1 5/16", mv_cnt - mv0, last_hi, last_per); end
        cyc(1'b1);
        cyc(1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.pwm = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        test_basic();
        test_latency();
        test_sweep();
        test_glitch();
        test_min_period();
        test_stuck();
        test_edge_vs_timeout();
        test_reset_mid();
        n_cmp++; if (b2b_cnt !== 0) begin n_err++; $display("FAIL back_to_back: got %0d want 0", b2b_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
